i2s_rx: RTL
===========

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter AUDIO_DW, default 16: sample width in bits per channel; legal range 8..32.
REQ-002 clk  input  1: system clock; all state is clocked on its rising edge.
REQ-003 reset  input  1: synchronous, active-high reset.
REQ-004 sclk  input  1: external I2S bit clock; asynchronous to clk.
REQ-005 lrclk  input  1: external word select, asynchronous; 0 = left, 1 = right.
REQ-006 sdata  input  1: external serial data, MSB first, asynchronous.
REQ-007 left_chan  output  AUDIO_DW: last complete left sample.
REQ-008 right_chan  output  AUDIO_DW: last complete right sample.
REQ-009 sample_valid  output  1: one-clk pulse when left_chan and right_chan update together.
REQ-010 frame_err  output  1: one-clk pulse flagging a malformed half-frame (see Configuration).

Function
REQ-011 sclk, lrclk and sdata SHALL each pass through a 2-flop synchronizer before use; clk SHALL be at least 4x sclk.
REQ-012 A "bit event" SHALL be a synchronized sclk 0->1 transition; synchronized sdata and lrclk SHALL be sampled on the same clk cycle.
REQ-013 Framing SHALL be Philips I2S: lrclk changes one bit before the MSB, so the bit event that first sees a new lrclk carries the LSB of the previous channel.
REQ-014 A bit counter SHALL reset to 0 at each lrclk change, and each bit event SHALL increment it, saturating at AUDIO_DW.
REQ-015 Each bit event with count < AUDIO_DW SHALL write sdata into shift-word position AUDIO_DW-1-count; bits beyond AUDIO_DW SHALL be dropped (truncate).
REQ-016 At each lrclk change, the shift word, including the current bit if count < AUDIO_DW, SHALL complete the previous channel; unfilled LSBs SHALL be 0 (left-justified).
REQ-017 A completed left word SHALL go to a staging register; a completed right word SHALL update right_chan, copy staging into left_chan, and pulse sample_valid in the same cycle.
REQ-018 sample_valid SHALL assert exactly 2 clk cycles after the bit event that completes the right word.
REQ-019 The first lrclk change after reset SHALL only arm the receiver; no word completes at it, and the first sample_valid SHALL need one full left and one full right half-frame.
REQ-020 sample_valid SHALL assert only if the staging register was written since the last pulse; a right word with no preceding left word SHALL be discarded.
REQ-021 left_chan and right_chan SHALL hold their value between pulses.
REQ-022 An lrclk change with no bit event SHALL be impossible by construction (lrclk is sampled only on bit events).

Reset
REQ-023 reset SHALL clear left_chan, right_chan, staging, the shift word, the counter, the armed flag, sample_valid and frame_err to 0.
REQ-024 Synchronizer flops SHALL reset to 0; the first bit event after reset SHALL need a synchronized sclk rise.
REQ-025 Reset mid-frame SHALL discard the partial word and re-arm per REQ-019.

Configuration
REQ-026 Macro I2S_RX_FRAME_CHECK_EN: when defined, frame_err SHALL pulse with each completed word whose received bit count (including the completing bit) is not exactly AUDIO_DW, and the word SHALL still be delivered per REQ-016/017.
REQ-027 Without I2S_RX_FRAME_CHECK_EN: frame_err SHALL be tied 0, no error logic SHALL be synthesized, and the port list SHALL be unchanged.

Structure
REQ-028 Package i2s_pkg SHALL hold the AUDIO_DW default, the sync depth (2) and the channel encoding constants (LEFT=0, RIGHT=1).
REQ-029 Sub-module i2s_sync_edge (2-flop synchronizer plus registered rising-edge detect, 1 bit wide) SHALL be instantiated once each for sclk, lrclk and sdata; edge output used for sclk only.

Verification
REQ-030 AUDIO_DW=16, frames L=16'hA55A R=16'h1234 repeated -> first pulse after 2nd full frame; left_chan=A55A, right_chan=1234, frame_err never set.
REQ-031 Transmitter using 12-bit halves, L=12'hABC R=12'h123 -> left_chan=16'hABC0, right_chan=16'h1230, frame_err pulses per word (macro on), 0 (macro off).
REQ-032 Transmitter using 24-bit halves, L=24'hCAFE77 R=24'h00BEEF -> left_chan=16'hCAFE, right_chan=16'h00BE, frame_err pulses per word (macro on).
REQ-033 Reset asserted for 1 clk after 7 left bits -> outputs 0, no pulse for the next full frame, then correct values on the following frame.
REQ-034 Stream beginning mid right half-frame (lrclk=1 at reset release) -> no sample_valid until a left then right half complete.
REQ-035 clk = 4x sclk, random 1000 sample pairs -> every pair matches in order, one pulse per frame, latency per REQ-018.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receiver: default sample width, synchronizer
// depth and the lrclk channel encoding.
package i2s_pkg;

  localparam int unsigned AUDIO_DW_DEFAULT = 16;
  localparam int unsigned SYNC_DEPTH       = 2;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Single-bit synchronizer with registered rising-edge detect. o_level and
// o_rise are aligned: both reflect the same synchronized sample.
module i2s_sync_edge
  import i2s_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_prev;
  logic                  r_rise;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
      r_prev <= r_sync[SYNC_DEPTH-1];
      r_rise <= r_sync[SYNC_DEPTH-1] & ~r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: deserialises left/right words and presents them as a
// pair. Optional word-length checking on frame_err via I2S_RX_FRAME_CHECK_EN.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned AUDIO_DW = AUDIO_DW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                frame_err
);

  localparam int unsigned CW = $clog2(AUDIO_DW + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(AUDIO_DW);

  logic w_sclk_level, w_sclk_rise;
  logic w_lrclk, w_lrclk_rise;
  logic w_sdata, w_sdata_rise;
  logic w_unused_sync;

  i2s_sync_edge u_sync_sclk (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (sclk),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise)
  );

  i2s_sync_edge u_sync_lrclk (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (lrclk),
    .o_level (w_lrclk),
    .o_rise  (w_lrclk_rise)
  );

  i2s_sync_edge u_sync_sdata (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (sdata),
    .o_level (w_sdata),
    .o_rise  (w_sdata_rise)
  );

  assign w_unused_sync = w_sclk_level ^ w_lrclk_rise ^ w_sdata_rise;

  // Front end: shift register and bit counter, advanced on bit events
  chan_e               r_lr_prev;
  logic                r_armed;
  cnt_t                r_cnt;
  logic [AUDIO_DW-1:0] r_shift;
  logic                r_done;
  chan_e               r_done_chan;
  logic [AUDIO_DW-1:0] r_done_word;

  chan_e               w_lr_chan;
  logic                w_change;
  logic                w_in_range;
  cnt_t                w_pos;
  logic [AUDIO_DW-1:0] w_bit_mask;
  logic [AUDIO_DW-1:0] w_word;
  logic                w_complete;

  always_comb begin
    w_lr_chan  = chan_e'(w_lrclk);
    w_change   = (w_lr_chan != r_lr_prev);
    w_in_range = (r_cnt < CNT_MAX);
    w_pos      = cnt_t'(AUDIO_DW - 1) - r_cnt;
    w_bit_mask = '0;
    if (w_in_range && w_sdata) begin
      w_bit_mask = {{(AUDIO_DW - 1){1'b0}}, 1'b1} << w_pos;
    end
    w_word     = r_shift | w_bit_mask;
    w_complete = w_sclk_rise & w_change & r_armed;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lr_prev   <= LEFT;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_done_chan <= LEFT;
      r_done_word <= '0;
    end else begin
      r_done <= w_complete;
      if (w_complete) begin
        r_done_chan <= r_lr_prev;
        r_done_word <= w_word;
      end
      if (w_sclk_rise) begin
        r_lr_prev <= w_lr_chan;
        // The bit that reveals a new lrclk is the LSB of the old word
        if (w_change) begin
          r_armed <= 1'b1;
          r_cnt   <= '0;
          r_shift <= '0;
        end else begin
          r_shift <= w_word;
          if (w_in_range) begin
            r_cnt <= r_cnt + cnt_t'(1);
          end
        end
      end
    end
  end

  // Back end: pair a staged left word with the following right word
  logic [AUDIO_DW-1:0] r_staging;
  logic                r_staged;
  logic [AUDIO_DW-1:0] r_left;
  logic [AUDIO_DW-1:0] r_right;
  logic                r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_staging <= '0;
      r_staged  <= 1'b0;
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_done) begin
        if (r_done_chan == LEFT) begin
          r_staging <= r_done_word;
          r_staged  <= 1'b1;
        end else if (r_staged) begin
          r_right  <= r_done_word;
          r_left   <= r_staging;
          r_valid  <= 1'b1;
          r_staged <= 1'b0;
        end
      end
    end
  end

  assign left_chan    = r_left;
  assign right_chan   = r_right;
  assign sample_valid = r_valid;

`ifdef I2S_RX_FRAME_CHECK_EN
  logic r_done_err;
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_err <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Received length is r_cnt + 1 (completing bit) unless saturated
      if (w_complete) begin
        r_done_err <= (r_cnt != CNT_MAX - cnt_t'(1));
      end
      r_err <= r_done & r_done_err;
    end
  end

  assign frame_err = r_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule
